siren_sweeper: RTL and testbench

- Parametrised multi-mode siren/tone generator for the audio path. Drives a square wave whose half-period, in clock cycles, is set by a registered endpoint.
- Four modes: off, steady tone, linear wail sweep between two frequencies, and hi-lo two-tone alternation.
- Exports the current half-period and a per-cycle completion strobe so the FSM above it can count siren cycles.
- Sits between the alarm control FSM and the audio output pin/PWM stage.

---
 rtl/siren_sweeper.sv | 163 ++++++++++++++++
 tb/tb_siren_sweeper.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/siren_sweeper.sv
// siren_sweeper: multi-mode square-wave siren generator (off / tone / wail / hi-lo).
// The half-period endpoint is registered; a free-running counter toggles the wave
// whenever it reaches the endpoint, and the endpoint is re-aimed on each toggle.
//
// mode_q | meaning
// -------+---------------------------------------------------------------
// OFF    | everything held at restart values, wave low
// TONE   | endpoint fixed at LO_HALF
// WAIL   | endpoint steps by STEP between LO_HALF and HI_HALF (dir DOWN/UP)
// HILO   | endpoint alternates LO_HALF / HI_HALF every DWELL toggles
//
// dir  | meaning
// -----+---------------------------------------------------------------
// DOWN | endpoint shrinking toward HI_HALF (frequency rising)
// UP   | endpoint growing toward LO_HALF; reaching LO_HALF ends one siren cycle
module siren_sweeper #(
  parameter int CNT_W   = 16,
  parameter int LO_HALF = 31250,
  parameter int HI_HALF = 17857,
  parameter int STEP    = 10,
  parameter int DWELL   = 200
) (
  input  logic             clock_25mhz,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic             audio_out,
  output logic [CNT_W-1:0] period_out,
  output logic             cycle_done
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_TONE = 2'b01;
  localparam logic [1:0] M_WAIL = 2'b10;
  localparam logic [1:0] M_HILO = 2'b11;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam logic [CNT_W-1:0] C_LO      = CNT_W'(LO_HALF);
  localparam logic [CNT_W-1:0] C_HI      = CNT_W'(HI_HALF);
  localparam logic [CNT_W:0]   C_LO_X    = (CNT_W+1)'(LO_HALF);
  localparam logic [CNT_W:0]   C_HI_X    = (CNT_W+1)'(HI_HALF);
  localparam logic [CNT_W:0]   C_STEP_X  = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] C_STEP    = CNT_W'(STEP);
  localparam logic [DW_W-1:0]  C_DW_LAST = DW_W'(DWELL - 1);

  logic [CNT_W-1:0] r_count,    w_count_nxt;
  logic [CNT_W-1:0] r_endpoint, w_endpoint_nxt;
  logic             r_dir,      w_dir_nxt;
  logic [DW_W-1:0]  r_dwell,    w_dwell_nxt;
  logic             r_audio,    w_audio_nxt;
  logic             r_done,     w_done_nxt;
  logic [1:0]       r_mode_q,   w_mode_q_nxt;

  logic             w_restart;
  logic             w_toggle;
  logic [CNT_W:0]   w_count_inc_x;
  logic [CNT_W:0]   w_ep_x;
  logic [CNT_W:0]   w_ep_up_x;
  logic [CNT_W:0]   w_dn_limit_x;

  // Wide (CNT_W+1) arithmetic so neither the terminal compare nor the sweep can wrap.
  assign w_count_inc_x = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
  assign w_ep_x        = {1'b0, r_endpoint};
  assign w_ep_up_x     = w_ep_x + C_STEP_X;
  assign w_dn_limit_x  = C_HI_X + C_STEP_X;

  // A mode change or OFF reloads restart values; >= tolerates an endpoint below count.
  assign w_restart = (mode != r_mode_q) || (r_mode_q == M_OFF);
  assign w_toggle  = (w_count_inc_x >= w_ep_x);

  // State register: synchronous reset wins over everything else.
  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      r_count    <= '0;
      r_endpoint <= C_LO;
      r_dir      <= DIR_DOWN;
      r_dwell    <= '0;
      r_audio    <= 1'b0;
      r_done     <= 1'b0;
      r_mode_q   <= mode;
    end else begin
      r_count    <= w_count_nxt;
      r_endpoint <= w_endpoint_nxt;
      r_dir      <= w_dir_nxt;
      r_dwell    <= w_dwell_nxt;
      r_audio    <= w_audio_nxt;
      r_done     <= w_done_nxt;
      r_mode_q   <= w_mode_q_nxt;
    end
  end

  // Next-state: restart, else toggle-driven endpoint update per mode, else count up.
  always_comb begin
    w_count_nxt    = r_count;
    w_endpoint_nxt = r_endpoint;
    w_dir_nxt      = r_dir;
    w_dwell_nxt    = r_dwell;
    w_audio_nxt    = r_audio;
    w_done_nxt     = 1'b0;
    w_mode_q_nxt   = r_mode_q;

    if (w_restart) begin
      w_count_nxt    = '0;
      w_endpoint_nxt = C_LO;
      w_dir_nxt      = DIR_DOWN;
      w_dwell_nxt    = '0;
      w_audio_nxt    = 1'b0;
      w_mode_q_nxt   = mode;
    end else if (w_toggle) begin
      w_count_nxt = '0;
      w_audio_nxt = ~r_audio;
      case (r_mode_q)
        M_WAIL: begin
          if (r_dir == DIR_DOWN) begin
            if (w_ep_x <= w_dn_limit_x) begin
              w_endpoint_nxt = C_HI;
              w_dir_nxt      = DIR_UP;
            end else begin
              w_endpoint_nxt = r_endpoint - C_STEP;
            end
          end else begin
            if (w_ep_up_x >= C_LO_X) begin
              w_endpoint_nxt = C_LO;
              w_dir_nxt      = DIR_DOWN;
              w_done_nxt     = 1'b1;
            end else begin
              w_endpoint_nxt = w_ep_up_x[CNT_W-1:0];
            end
          end
        end
        M_HILO: begin
          if (r_dwell == C_DW_LAST) begin
            w_dwell_nxt = '0;
            if (r_endpoint == C_HI) begin
              w_endpoint_nxt = C_LO;
              w_done_nxt     = 1'b1;
            end else begin
              w_endpoint_nxt = C_HI;
            end
          end else begin
            w_dwell_nxt = r_dwell + DW_W'(1);
          end
        end
        M_TONE:  w_endpoint_nxt = C_LO;
        default: w_endpoint_nxt = C_LO;
      endcase
    end else begin
      w_count_nxt = w_count_inc_x[CNT_W-1:0];
    end
  end

  // Outputs: enable gates the registered wave only; sweep state is unaffected.
  always_comb begin
    audio_out  = enable & r_audio;
    period_out = r_endpoint;
    cycle_done = r_done;
  end

endmodule

// File: tb/tb_siren_sweeper.sv
// tb_siren_sweeper: randomized stimulus against a half-period sequence model.
// The model lists every half-period of one siren cycle per mode and just walks
// that list, counting cycles inside the current half-period.
`timescale 1ns/1ps
module tb_siren_sweeper;

  localparam int CNT_W   = 16;
  localparam int LO_HALF = 20;
  localparam int HI_HALF = 10;
  localparam int STEP    = 3;
  localparam int DWELL   = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic [1:0]       md;
  logic             audio;
  logic [CNT_W-1:0] period;
  logic             done;

  int n_vec;
  int n_err;

  siren_sweeper #(
    .CNT_W(CNT_W), .LO_HALF(LO_HALF), .HI_HALF(HI_HALF), .STEP(STEP), .DWELL(DWELL)
  ) u_dut (
    .clock_25mhz(clk),
    .reset      (rst),
    .enable     (en),
    .mode       (md),
    .audio_out  (audio),
    .period_out (period),
    .cycle_done (done)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Half-period lists for one complete siren cycle.
  int wail_seq[$];
  int hilo_seq[$];

  // Model state.
  logic [1:0] m_mode;
  int         m_idx;
  int         m_el;
  logic       m_lvl;
  logic       m_done;

  function automatic int cur_half();
    case (m_mode)
      2'b10:   return wail_seq[m_idx];
      2'b11:   return hilo_seq[m_idx];
      default: return LO_HALF;
    endcase
  endfunction

  function automatic int seq_len();
    case (m_mode)
      2'b10:   return wail_seq.size();
      2'b11:   return hilo_seq.size();
      default: return 1;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] mm);
    if (r || (mm != m_mode) || (m_mode == 2'b00)) begin
      m_mode = mm;
      m_idx  = 0;
      m_el   = 0;
      m_lvl  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_el == cur_half() - 1) begin
        m_el  = 0;
        m_lvl = ~m_lvl;
        m_idx = m_idx + 1;
        if (m_idx == seq_len()) begin
          m_idx  = 0;
          m_done = (m_mode == 2'b10) || (m_mode == 2'b11);
        end
      end else begin
        m_el = m_el + 1;
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare just after it.
  task automatic cycle(input logic r, input logic [1:0] mm, input logic e);
    rst = r;
    md  = mm;
    en  = e;
    @(posedge clk);
    model_step(r, mm);
    #1;
    check_eq("audio_out",  {31'd0, audio},  {31'd0, (e & m_lvl)});
    check_eq("period_out", {16'd0, period}, cur_half());
    check_eq("cycle_done", {31'd0, done},   {31'd0, m_done});
  endtask

  initial begin
    int   guard;
    logic e;
    logic [1:0] mm;
    n_vec = 0;
    n_err = 0;

    for (int v = LO_HALF; v > HI_HALF; v -= STEP) wail_seq.push_back(v);
    for (int v = HI_HALF; v < LO_HALF; v += STEP) wail_seq.push_back(v);
    for (int k = 0; k < DWELL; k++) hilo_seq.push_back(LO_HALF);
    for (int k = 0; k < DWELL; k++) hilo_seq.push_back(HI_HALF);

    m_mode = 2'b00;
    m_idx  = 0;
    m_el   = 0;
    m_lvl  = 1'b0;
    m_done = 1'b0;

    // Initial reset, then reset held 3 cycles in the middle of a wail sweep.
    rst = 1'b1; md = 2'b00; en = 1'b1;
    repeat (2) cycle(1'b1, 2'b00, 1'b1);
    repeat (57) cycle(1'b0, 2'b10, 1'b1);
    repeat (3) cycle(1'b1, 2'b10, 1'b1);
    repeat (300) cycle(1'b0, 2'b10, 1'b1);

    // Wail until the endpoint is 14, then switch to tone.
    guard = 0;
    while (cur_half() != 14 && guard < 400) begin
      cycle(1'b0, 2'b10, 1'b1);
      guard++;
    end
    check_eq("reach_period_14", cur_half(), 14);
    repeat (100) cycle(1'b0, 2'b01, 1'b1);

    // Hi-lo for more than two full cycles.
    repeat (150) cycle(1'b0, 2'b11, 1'b1);

    // Wail with enable dropped for 100 cycles mid-sweep.
    repeat (40) cycle(1'b0, 2'b10, 1'b1);
    repeat (100) cycle(1'b0, 2'b10, 1'b0);
    repeat (150) cycle(1'b0, 2'b10, 1'b1);

    // Randomized segments: random mode, sparse enable flips and resets.
    e = 1'b1;
    for (int s = 0; s < 60; s++) begin
      mm = 2'($urandom_range(0, 3));
      for (int c = 0; c < int'($urandom_range(10, 300)); c++) begin
        if ($urandom_range(0, 39) == 0) e = ~e;
        cycle(($urandom_range(0, 499) == 0), mm, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
